// File: rtl/fft32_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fft32_stage_sequencer
// Description : Pipeline controller for the 32-point FFT stage chain.
//               Accepts frames over a valid/ready handshake and produces one
//               register enable per FFT stage. It tracks which stages hold a
//               live frame, applies output backpressure and flush, and drives
//               the constant W8^k twiddle words consumed by Stage2.
//
// Parameters  : p_numStages     - registered FFT stages sequenced (>= 2)
//               p_widdleBits    - twiddle word width, packed {real, imag}
//               p_realBits      - width of the real field (upper bits)
//               p_PointPosition - fractional bits in each twiddle field
//
// Ports       : CLK            in   clock
//               RST            in   asynchronous active-low reset
//               i_frame_valid  in   upstream frame present on stage-1 inputs
//               o_frame_ready  out  frame accepted this cycle when valid
//               i_out_ready    in   downstream consumes final-stage output
//               o_out_valid    out  final-stage registers hold a frame
//               i_flush        in   synchronous pipeline discard
//               o_stage_en     out  per-stage enable, bit k -> stage k+1
//               o_busy         out  pipeline non-empty or flushing
//               o_w08..o_w38   out  Stage2 twiddles W8^0..W8^3
//
// Option      : FFT_SEQ_PERF_EN adds saturating counters o_frames_out,
//               o_stall_cycles and o_flush_count (cleared by RST only).
//
// Revision    : 1.0 - initial release
// ============================================================================
module fft32_stage_sequencer #(
    parameter int p_numStages     = 5,
    parameter int p_widdleBits    = 16,
    parameter int p_realBits      = 8,
    parameter int p_PointPosition = 3
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    i_frame_valid,
    output logic                    o_frame_ready,
    input  logic                    i_out_ready,
    output logic                    o_out_valid,
    input  logic                    i_flush,
    output logic [p_numStages-1:0]  o_stage_en,
    output logic                    o_busy,
    output logic [p_widdleBits-1:0] o_w08,
    output logic [p_widdleBits-1:0] o_w18,
    output logic [p_widdleBits-1:0] o_w28,
    output logic [p_widdleBits-1:0] o_w38
`ifdef FFT_SEQ_PERF_EN
    ,
    output logic [15:0]             o_frames_out,
    output logic [15:0]             o_stall_cycles,
    output logic [7:0]              o_flush_count
`endif
);

    // ------------------------------------------------------------------------
    // Twiddle constants
    // ------------------------------------------------------------------------
    localparam int c_IMAG_BITS = p_widdleBits - p_realBits;

    // 1.0 and round(cos(pi/4)) in the chosen fixed-point format.
    // 46341/65536 approximates 1/sqrt(2); +32768 before the shift rounds.
    localparam int c_ONE = 1 << p_PointPosition;
    localparam int c_R2  = ((1 << p_PointPosition) * 46341 + 32768) >>> 16;

    localparam logic [p_realBits-1:0]  c_RE_ONE  = p_realBits'(c_ONE);
    localparam logic [p_realBits-1:0]  c_RE_ZERO = '0;
    localparam logic [p_realBits-1:0]  c_RE_R2   = p_realBits'(c_R2);
    localparam logic [p_realBits-1:0]  c_RE_NR2  = p_realBits'(-c_R2);
    localparam logic [c_IMAG_BITS-1:0] c_IM_ZERO = '0;
    localparam logic [c_IMAG_BITS-1:0] c_IM_NR2  = c_IMAG_BITS'(-c_R2);
    localparam logic [c_IMAG_BITS-1:0] c_IM_NONE = c_IMAG_BITS'(-c_ONE);

    // W8^k = exp(-j*2*pi*k/8): imaginary parts are zero or negative.
    assign o_w08 = {c_RE_ONE,  c_IM_ZERO};
    assign o_w18 = {c_RE_R2,   c_IM_NR2};
    assign o_w28 = {c_RE_ZERO, c_IM_NONE};
    assign o_w38 = {c_RE_NR2,  c_IM_NR2};

    // ------------------------------------------------------------------------
    // Control FSM and occupancy
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [p_numStages-1:0]   r_occ;
    logic [p_numStages-1:0]   w_occ_next;
    logic                     w_stall;
    logic                     w_ready;
    logic                     w_accept;
    logic                     w_advance;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_IDLE;
            r_occ   <= '0;
        end else begin
            r_state <= w_state_next;
            r_occ   <= w_occ_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_occ_next   = r_occ;

        w_stall   = r_occ[p_numStages-1] & ~i_out_ready;
        // Ready is also held low while RST is asserted so that no stage
        // enable can fire during reset.
        w_ready   = RST & ~w_stall & (r_state != S_FLUSH);
        w_accept  = i_frame_valid & w_ready;
        // Interior stages move only when nothing blocks the whole chain.
        w_advance = ~w_stall & ~i_flush & (r_state != S_FLUSH);

        // Flush wins over both stall and accept.
        if (i_flush || (r_state == S_FLUSH)) begin
            w_occ_next = '0;
        end else if (!w_stall) begin
            w_occ_next = {r_occ[p_numStages-2:0], w_accept};
        end

        case (r_state)
            S_IDLE: begin
                if (i_flush) begin
                    w_state_next = S_FLUSH;
                end else if (w_accept) begin
                    w_state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (i_flush) begin
                    w_state_next = S_FLUSH;
                end else if (w_occ_next == '0) begin
                    w_state_next = S_IDLE;
                end
            end
            S_FLUSH: begin
                // A fresh flush request re-arms the discard cycle.
                w_state_next = i_flush ? S_FLUSH : S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign o_frame_ready = w_ready;
    assign o_out_valid   = r_occ[p_numStages-1];
    assign o_busy        = (r_state != S_IDLE);
    assign o_stage_en    = {r_occ[p_numStages-2:0] & {(p_numStages-1){w_advance}},
                            w_accept & ~i_flush};

`ifdef FFT_SEQ_PERF_EN
    // ------------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------------
    logic [15:0] r_frames_out;
    logic [15:0] r_stall_cycles;
    logic [7:0]  r_flush_count;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_frames_out   <= '0;
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (o_out_valid && i_out_ready && (r_frames_out != '1)) begin
                r_frames_out <= r_frames_out + 16'd1;
            end
            if (w_stall && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 16'd1;
            end
            if (i_flush && (r_flush_count != '1)) begin
                r_flush_count <= r_flush_count + 8'd1;
            end
        end
    end

    assign o_frames_out   = r_frames_out;
    assign o_stall_cycles = r_stall_cycles;
    assign o_flush_count  = r_flush_count;
`endif

endmodule
`default_nettype wire

// File: doc/fft32_stage_sequencer.md
Name: fft32_stage_sequencer

Overview:
- Pipeline controller for the 32-point FFT datapath: five registered butterfly stages, Stage1 to Stage5, each one clock deep.
- Accepts frames with a valid/ready handshake and generates a per-stage clock enable.
- Tracks pipeline occupancy, applies output backpressure and flush, and drives the constant W8 twiddle words into Stage2.
- Sits between the sample-frame buffer and the FFT stage chain.

Parameters:
- p_numStages, 5, number of registered FFT stages sequenced (≥2).
- p_widdleBits, 16, twiddle word width: {real, imag}, two's complement.
- p_realBits, 8, width of the real field (upper bits); imag field = p_widdleBits-p_realBits.
- p_PointPosition, 3, fractional bits in each twiddle field.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous active-low reset.
- i_frame_valid  in  1  upstream has a full 32-sample frame on the stage-1 inputs.
- o_frame_ready  out  1  controller accepts a frame this cycle.
- i_out_ready  in  1  downstream consumes the final-stage output.
- o_out_valid  out  1  final-stage registers hold a valid frame.
- i_flush  in  1  synchronous pipeline discard.
- o_stage_en  out  p_numStages  register enable per stage; bit k drives stage k+1.
- o_busy  out  1  pipeline non-empty or flushing.
- o_w08, o_w18, o_w28, o_w38  out  p_widdleBits each  Stage2 twiddles W8^0..W8^3.

Behaviour:
- Reset (RST=0, asynchronous):
  - Occupancy vector v[p_numStages-1:0]=0 and FSM=IDLE.
  - o_out_valid=0, o_busy=0, o_stage_en=0.
  - o_frame_ready=1 once RST releases.
- stall = o_out_valid & ~i_out_ready.
- o_frame_ready = ~stall & (state!=FLUSH).
- accept = i_frame_valid & o_frame_ready.
- Enables:
  - o_stage_en[0] = accept & ~i_flush.
  - o_stage_en[k] = v[k-1] & ~stall & ~i_flush, for k≥1.
- Occupancy update:
  - If ~stall & ~i_flush: v <= {v[N-2:0], accept}.
  - If stall: v holds.
  - o_out_valid = v[N-1].
- Latency: a frame accepted in cycle t gives o_out_valid in cycle t+N (t+5 by default). Throughput is one frame per cycle with no bubbles while i_out_ready=1.
- Backpressure:
  - While stall, all enables are 0, v and the stage data hold, and o_frame_ready=0.
  - The frame is consumed in the first cycle that has o_out_valid & i_out_ready.
- FSM (2-bit):
  - IDLE: v==0. Goes to BUSY on accept, to FLUSH on i_flush.
  - BUSY: goes to IDLE when next v==0, to FLUSH on i_flush.
  - FLUSH: lasts one cycle. v<=0, o_frame_ready=0, o_stage_en=0. Then returns to IDLE.
  - Any i_flush high has priority over accept and stall in the same cycle; the frame offered in that cycle is not accepted.
- o_busy = (state!=IDLE).
- Simultaneous events:
  - Accept and output consume in the same cycle are both honoured.
  - During a stall, accept cannot occur because ready=0.
- Twiddles: constant, round-to-nearest of W8^k = e^(-j2πk/8) scaled by 2^p_PointPosition, packed {re,im}. Defaults:
  - W08 = 16'h0800 (+8, 0).
  - W18 = 16'h06FA (+6, -6).
  - W28 = 16'h00F8 (0, -8).
  - W38 = 16'hFAFA (-6, -6).
- Twiddles are valid immediately out of reset and are unaffected by flush.

Optional Feature:
- Macro FFT_SEQ_PERF_EN.
- When defined, three outputs are added:
  - o_frames_out (16-bit): counts output handshakes.
  - o_stall_cycles (16-bit): counts cycles with stall=1.
  - o_flush_count (8-bit): counts flushes.
- All three saturate at all-ones and clear on RST only.
- When undefined, these ports and counters are absent and all other behaviour is identical.

Test Plan:
- Reset, then single frame: pulse i_frame_valid in cycle 0 with i_out_ready=1. Required: o_stage_en walks bit0..bit4 over cycles 0..4; o_out_valid high in cycle 5 only; o_busy high cycles 1..5.
- Back-to-back: i_frame_valid=1 for 8 cycles with i_out_ready=1. Required: o_frame_ready stays 1; o_out_valid high cycles 5..12; 8 handshakes.
- Backpressure: stream frames, drop i_out_ready for 3 cycles once o_out_valid=1. Required: o_stage_en=0 and o_frame_ready=0 for those 3 cycles; no frame lost or duplicated; order preserved.
- Flush mid-stream: 3 frames in flight, assert i_flush with i_frame_valid=1. Required: next cycle v=0, o_out_valid=0, o_frame_ready=0 for one cycle, then IDLE; the offered frame is not accepted.
- Async reset mid-operation: drop RST between clock edges with a full pipeline. Required: outputs clear immediately; after release, twiddles read 0800/06FA/00F8/FAFA.
- With FFT_SEQ_PERF_EN: run 4 frames, 2 stall cycles and 1 flush. Required: counters read 4, 2 and 1 respectively.
